// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared types and defaults for the trace-to-UART transmit buffer.
// Revision : 1.0
// ============================================================================
package trace_pkg;

    localparam int c_DEPTH_LOG2   = 8;
    localparam int c_BUSY_TIMEOUT = 4;
    localparam int c_DROP_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LAUNCH     = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo_mem
// Brief    : Simple dual-port RAM, registered write and synchronous read.
// Revision : 1.0
// ============================================================================
module trace_fifo_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // No reset on the array or read register so the RAM maps onto block memory.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : trace_tx_buffer
// Brief    : Elastic byte FIFO pacing trace bytes into a UART transmitter.
// Revision : 1.0
// ============================================================================
module trace_tx_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH_LOG2   = c_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = c_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  dvalid,
    input  logic [7:0]            dIn,
    input  logic                  txBusy,
    input  logic                  clrOvf,
    output logic                  transmit,
    output logic [7:0]            txByte,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    output logic [c_DROP_W-1:0]   dropCount,
    output logic                  timeoutErr
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_LW    = DEPTH_LOG2 + 1;
    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    rd_state_t             r_state;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic                  r_transmit;
    logic                  r_tx_loaded;
    logic                  r_ovf;
    logic                  r_timeout_err;
    logic [c_DROP_W-1:0]   r_drop_cnt;

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_timeout;
    logic [7:0] w_rdata;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_LW'(c_DEPTH));
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && !txBusy;
    assign w_push    = dvalid && (!w_full || w_pop);
    assign w_drop    = dvalid && w_full && !w_pop;
    assign w_timeout = (r_state == ST_WAIT_START) && !txBusy &&
                       (r_wait_cnt == c_CNT_W'(BUSY_TIMEOUT - 1));

    trace_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (8)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (dIn),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_ovf         <= 1'b0;
            r_drop_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (clrOvf)
                    r_drop_cnt <= c_DROP_W'(1);
                else if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end else if (clrOvf) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end
            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if (clrOvf)
                r_timeout_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state     <= ST_IDLE;
            r_transmit  <= 1'b0;
            r_wait_cnt  <= '0;
            r_tx_loaded <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_transmit <= 1'b0;
                    if (w_pop) begin
                        r_state     <= ST_LAUNCH;
                        r_transmit  <= 1'b1;
                        r_tx_loaded <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    r_transmit <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (txBusy)
                        r_state <= ST_WAIT_DONE;
                    else if (w_timeout)
                        r_state <= ST_IDLE;
                    else
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (!txBusy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The RAM read register holds the launched byte until the next pop;
    // the mask gives a defined zero before the first launch after reset.
    assign txByte     = r_tx_loaded ? w_rdata : 8'h00;
    assign transmit   = r_transmit;
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_level;
    assign ovf        = r_ovf;
    assign dropCount  = r_drop_cnt;
    assign timeoutErr = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_trace_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_tx_buffer
// Brief    : Self-checking bench with a UART model and a queue-based reference.
// Revision : 1.0
// ============================================================================
module tb_trace_tx_buffer;

    localparam int BT    = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        dvalid = 1'b0;
    logic [7:0]  dIn = 8'h00;
    logic        clrOvf = 1'b0;
    logic        hold_busy = 1'b0;
    logic        model_busy = 1'b0;
    logic        txBusy;
    logic        transmit;
    logic [7:0]  txByte;
    logic        empty;
    logic        full;
    logic [8:0]  level;
    logic        ovf;
    logic [15:0] dropCount;
    logic        timeoutErr;

    int checks = 0;
    int errors = 0;

    int uart_en    = 1;
    int uart_delay = 2;
    int uart_hold  = 10;
    int start_in   = 0;
    int hold_left  = 0;
    int tx_pulses  = 0;
    logic [7:0] got_q[$];

    assign txBusy = hold_busy | model_busy;

    trace_tx_buffer dut (
        .clk        (clk),
        .nRst       (nRst),
        .dvalid     (dvalid),
        .dIn        (dIn),
        .txBusy     (txBusy),
        .clrOvf     (clrOvf),
        .transmit   (transmit),
        .txByte     (txByte),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .ovf        (ovf),
        .dropCount  (dropCount),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    // UART model and output monitor: busy rises uart_delay cycles after a
    // transmit pulse and stays high for uart_hold cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_in > 0) begin
                start_in--;
                if (start_in == 0) begin
                    model_busy = 1'b1;
                    hold_left  = uart_hold;
                end
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) model_busy = 1'b0;
            end
            if (transmit === 1'b1) begin
                got_q.push_back(txByte);
                tx_pulses++;
                if (uart_en != 0) start_in = uart_delay;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d bytes, required %0d", nm, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        step();
        step();
        checks++;
        if ({level, empty, full, transmit, txByte, ovf, dropCount, timeoutErr} !==
            {9'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: level=%0d empty=%b full=%b tx=%b byte=%h ovf=%b drop=%0d terr=%b, required 0 1 0 0 00 0 0 0",
                     level, empty, full, transmit, txByte, ovf, dropCount, timeoutErr);
        end
        nRst = 1'b1;
        step();
    endtask

    task automatic test_single();
        got_q.delete();
        tx_pulses = 0;
        uart_en   = 1;
        dIn    = 8'hA5;
        dvalid = 1'b1;
        step();
        dvalid = 1'b0;
        checks++;
        if ({empty, level, transmit} !== {1'b0, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_cycle1: empty=%b level=%0d tx=%b, required 0 1 0", empty, level, transmit);
        end
        step();
        checks++;
        if ({transmit, txByte, level} !== {1'b1, 8'hA5, 9'd0}) begin
            errors++;
            $display("FAIL single_cycle2: tx=%b byte=%h level=%0d, required 1 a5 0", transmit, txByte, level);
        end
        repeat (20) step();
        checks++;
        if (tx_pulses != 1 || level !== 9'd0 || txByte !== 8'hA5) begin
            errors++;
            $display("FAIL single_after: pulses=%0d level=%0d byte=%h, required 1 0 a5", tx_pulses, level, txByte);
        end
    endtask

    task automatic test_fill();
        hold_busy = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            dIn    = 8'(i);
            dvalid = 1'b1;
            step();
        end
        dvalid = 1'b0;
        checks++;
        if ({level, full, empty, ovf, dropCount, transmit} !==
            {9'd256, 1'b1, 1'b0, 1'b1, 16'd44, 1'b0}) begin
            errors++;
            $display("FAIL fill: level=%0d full=%b empty=%b ovf=%b drop=%0d tx=%b, required 256 1 0 1 44 0",
                     level, full, empty, ovf, dropCount, transmit);
        end
    endtask

    task automatic test_clr_drop();
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        checks++;
        if ({ovf, dropCount} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL clear_only: ovf=%b drop=%0d, required 0 0", ovf, dropCount);
        end
        clrOvf = 1'b1;
        dvalid = 1'b1;
        dIn    = 8'hEE;
        step();
        clrOvf = 1'b0;
        dvalid = 1'b0;
        checks++;
        if ({ovf, dropCount, level} !== {1'b1, 16'd1, 9'd256}) begin
            errors++;
            $display("FAIL clear_with_drop: ovf=%b drop=%0d level=%0d, required 1 1 256", ovf, dropCount, level);
        end
    endtask

    task automatic test_drain();
        int bad;
        got_q.delete();
        hold_busy = 1'b0;
        wait_out(DEPTH, DEPTH * 20, "drain_timeout");
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= got_q.size() || got_q[i] !== 8'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_order: %0d bytes out of order, required 0", bad);
        end
        repeat (20) step();
        checks++;
        if ({level, empty, full, ovf, dropCount} !== {9'd0, 1'b1, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL drain_end: level=%0d empty=%b full=%b ovf=%b drop=%0d, required 0 1 0 1 1",
                     level, empty, full, ovf, dropCount);
        end
    endtask

    task automatic test_timeout();
        int gap;
        uart_en = 0;
        clrOvf  = 1'b1;
        step();
        clrOvf = 1'b0;
        got_q.delete();
        tx_pulses = 0;
        dIn    = 8'h11;
        dvalid = 1'b1;
        step();
        dIn = 8'h22;
        step();
        dvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (transmit === 1'b1) break;
            step();
        end
        gap = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == BT) begin
                checks++;
                if (timeoutErr !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: terr=%b, required 0", timeoutErr);
                end
            end
            if (k == BT + 1) begin
                checks++;
                if (timeoutErr !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_flag: terr=%b, required 1", timeoutErr);
                end
            end
            if (transmit === 1'b1) begin
                gap = k;
                break;
            end
        end
        checks++;
        if (gap != BT + 2 || txByte !== 8'h22) begin
            errors++;
            $display("FAIL timeout_relaunch: gap=%0d byte=%h, required %0d 22", gap, txByte, BT + 2);
        end
        repeat (12) step();
        checks++;
        if (tx_pulses != 2 || level !== 9'd0 || got_q.size() != 2 || got_q[0] !== 8'h11) begin
            errors++;
            $display("FAIL timeout_count: pulses=%0d level=%0d, required 2 0", tx_pulses, level);
        end
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        checks++;
        if (timeoutErr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: terr=%b, required 0", timeoutErr);
        end
        uart_en = 1;
    endtask

    task automatic test_reset_half();
        hold_busy = 1'b1;
        step();
        for (int i = 0; i < 128; i++) begin
            dIn    = 8'($urandom);
            dvalid = 1'b1;
            step();
        end
        dvalid = 1'b0;
        checks++;
        if (level !== 9'd128) begin
            errors++;
            $display("FAIL half_level: level=%0d, required 128", level);
        end
        nRst = 1'b0;
        step();
        checks++;
        if ({level, empty, transmit, txByte, ovf} !== {9'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_half: level=%0d empty=%b tx=%b byte=%h ovf=%b, required 0 1 0 00 0",
                     level, empty, transmit, txByte, ovf);
        end
        nRst = 1'b1;
        hold_busy = 1'b0;
        got_q.delete();
        repeat (20) step();
        checks++;
        if (got_q.size() != 0 || level !== 9'd0) begin
            errors++;
            $display("FAIL reset_discard: launched=%0d level=%0d, required 0 0", got_q.size(), level);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        logic [7:0] v;
        int bad;
        got_q.delete();
        for (int i = 0; i < 600; i++) begin
            v = 8'($urandom);
            sent.push_back(v);
            dIn    = v;
            dvalid = 1'b1;
            step();
            dvalid = 1'b0;
            repeat ($urandom_range(11, 17)) step();
        end
        wait_out(600, 6000, "wrap_timeout");
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if (i >= got_q.size() || got_q[i] !== sent[i]) bad++;
        end
        checks++;
        if (bad != 0 || got_q.size() != 600) begin
            errors++;
            $display("FAIL wrap_sequence: %0d bad of %0d received, required 0 of 600", bad, got_q.size());
        end
        repeat (20) step();
        checks++;
        if ({ovf, dropCount, level, empty} !== {1'b0, 16'd0, 9'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_end: ovf=%b drop=%0d level=%0d empty=%b, required 0 0 0 1",
                     ovf, dropCount, level, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_clr_drop();
        test_drain();
        test_timeout();
        test_reset_half();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_tx_buffer.md
# trace_tx_buffer

Byte-wide elastic buffer between the trace interface (producer of `dvalid`/`dOut` byte strobes) and the UART transmitter (consumer via `transmit`/`tx_byte`, busy via `is_transmitting`). Absorbs trace bursts that arrive faster than the UART line rate and paces bytes one at a time into the UART. Replaces the UART's internal overflow path with a sticky overflow flag and a drop counter.

## Interface
- `DEPTH_LOG2`, 8, FIFO depth is 2^DEPTH_LOG2 bytes (256).
- `BUSY_TIMEOUT`, 4, cycles after `transmit` to wait for `txBusy` to assert before abandoning the handshake.
- `clk` in 1, system clock (PLL output). Single clock domain.
- `nRst` in 1, reset. Synchronous, active-low.
- `dvalid` in 1, one-cycle strobe: `dIn` holds a valid trace byte.
- `dIn` in 8, trace byte.
- `txBusy` in 1, UART `is_transmitting`.
- `clrOvf` in 1, one-cycle strobe: clear `ovf` and `dropCount`.
- `transmit` out 1, one-cycle strobe to the UART `transmit` input.
- `txByte` out 8, byte to the UART `tx_byte` input.
- `empty` out 1, FIFO empty.
- `full` out 1, FIFO full.
- `level` out DEPTH_LOG2+1, current occupancy, 0..2^DEPTH_LOG2.
- `ovf` out 1, sticky: at least one byte dropped since reset/clear.
- `dropCount` out 16, dropped bytes, saturates at 16'hFFFF.
- `timeoutErr` out 1, sticky: a handshake timed out since reset/clear.

## Operation
- Reset (`nRst`=0 at a `clk` edge): pointers, `level`, `dropCount` = 0; `empty`=1; `full`, `transmit`, `ovf`, `timeoutErr` = 0; `txByte` = 8'h00; FSM = IDLE. Reset mid-transfer discards FIFO contents and any launched byte without waiting for `txBusy`.
- Write: `dvalid` && (!`full` || pop this cycle) → store `dIn` at write pointer, advance the pointer (wraps modulo depth).
- Drop: `dvalid` && `full` && no pop → byte discarded, `ovf`←1, `dropCount`+1 (saturating).
- `clrOvf` clears `ovf`, `dropCount`, and `timeoutErr`. If a drop coincides with `clrOvf`, the drop wins: `ovf`=1, `dropCount`=1.
- `level` tracks writes − pops. A simultaneous write and pop leaves it unchanged.
- Read FSM:
  - IDLE: if !`empty` && !`txBusy` → LAUNCH. Head byte is latched into `txByte` and popped on this transition.
  - LAUNCH: `transmit`=1 for exactly this cycle → WAIT_START.
  - WAIT_START: `txBusy`=1 → WAIT_DONE. Otherwise, after BUSY_TIMEOUT cycles here → IDLE with `timeoutErr`←1. The byte counts as consumed and is not retried.
  - WAIT_DONE: `txBusy`=0 → IDLE.
- `txByte` stays stable from LAUNCH until the FSM next leaves IDLE.

## Timing
- Write to `level`/`empty` update: 1 cycle.
- Minimum latency from `dvalid` into an empty FIFO with idle UART:
  - `dvalid` at cycle 0
  - `empty`=0 at cycle 1
  - IDLE→LAUNCH at the cycle 1 edge
  - `transmit`=1 during cycle 2
- Back-to-back bytes: at least 1 IDLE cycle after `txBusy` falls before the next `transmit`.
- `full` asserts the cycle after the write that brings `level` to 2^DEPTH_LOG2.
- Pointer wrap at 2^DEPTH_LOG2−1 → 0 is seamless. `full`/`empty` come from `level`, not from pointer equality.
- Sustained `dvalid` every cycle: accepted until full, then exactly one byte is accepted per pop.

## Structure
- Shared package `trace_pkg`: read FSM state enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE), default `DEPTH_LOG2`, `BUSY_TIMEOUT`, and the `dropCount` width constant.
- Sub-module `trace_fifo_mem`: simple dual-port RAM, registered write, synchronous read, inferable as iCE40 EBR.
- Pointers, `level`, drop logic and FSM live in `trace_tx_buffer`.

## Test plan
- Reset with FIFO half full → after one edge with `nRst`=0: `level`=0, `empty`=1, `transmit`=0, `txByte`=8'h00, `ovf`=0.
- Single byte 8'hA5 into an idle system, UART model raising `txBusy` 2 cycles after `transmit` and holding it 10 cycles → `transmit` pulses once at cycle 2, `txByte`=8'hA5, `level` returns to 0.
- Write 300 bytes, one per cycle, with `txBusy` held high → `level`=256, `full`=1, `ovf`=1, `dropCount`=44. Releasing the UART then drains 256 bytes in order 0..255.
- `clrOvf` and a drop in the same cycle → `ovf`=1, `dropCount`=1.
- UART model never asserts `txBusy` → after `transmit`, FSM returns to IDLE in BUSY_TIMEOUT+1 cycles, `timeoutErr`=1, and the next byte is launched.
- Write 600 bytes at the UART drain rate (pointer wraps twice) → output sequence matches input, `ovf` stays 0.
